// File: rtl/res_block_pkg.sv
// Shared types and encodings for the residual-block sequencer.
package res_block_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_A   = 3'd1,
    ST_RUN_B   = 3'd2,
    ST_RUN_ADD = 3'd3,
    ST_FIN     = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CONV_A   = 2'd0;
  localparam logic [1:0] ERR_CONV_B   = 2'd1;
  localparam logic [1:0] ERR_SHORTCUT = 2'd2;
  localparam logic [1:0] ERR_ADD      = 2'd3;

  localparam int DEFAULT_TIMEOUT = 4096;

  function automatic logic is_run(input state_t s);
    is_run = (s == ST_RUN_A) || (s == ST_RUN_B) || (s == ST_RUN_ADD);
  endfunction

endpackage

// File: rtl/res_block_seq_edge_det.sv
// One-bit rising-edge detector; a level held across cycles produces a single event.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_r;

  // Previous sample of the input
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= din;
    end
  end

  assign rise = din & ~prev_r;

endmodule

// File: rtl/res_block_seq.sv
// Start/done sequencer for one residual block: conv_a -> conv_b, shortcut in
// parallel, then the elementwise add; reports done, timeouts and latency.
module res_block_seq
  import res_block_pkg::*;
#(
  parameter int USE_SHORTCUT = 1,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_stage,
  output logic [CNT_WIDTH-1:0] latency,
  output logic                 conv_a_start,
  output logic                 conv_b_start,
  output logic                 sc_start,
  output logic                 add_start,
  input  logic                 conv_a_done,
  input  logic                 conv_b_done,
  input  logic                 sc_done,
  input  logic                 add_done
);

  localparam logic                 HAS_SC   = (USE_SHORTCUT != 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic [CNT_WIDTH-1:0] stage_cnt_r;
  logic [CNT_WIDTH-1:0] lat_cnt_r;
  logic                 sc_ok_r;
  logic                 b_ok_r;

  logic a_rise_s, b_rise_s, sc_rise_s, add_rise_s;
  logic a_ev_s, b_ev_s, sc_ev_s, add_ev_s;
  logic sc_ok_s, b_now_s, timeout_s;
  logic [CNT_WIDTH-1:0] lat_next_s;

  edge_det u_ed_a   (.clk(clk), .rst(rst), .din(conv_a_done), .rise(a_rise_s));
  edge_det u_ed_b   (.clk(clk), .rst(rst), .din(conv_b_done), .rise(b_rise_s));
  edge_det u_ed_sc  (.clk(clk), .rst(rst), .din(sc_done),     .rise(sc_rise_s));
  edge_det u_ed_add (.clk(clk), .rst(rst), .din(add_done),    .rise(add_rise_s));

  // An edge coinciding with the unit's own start pulse belongs to a previous job
  assign a_ev_s   = a_rise_s   & ~conv_a_start;
  assign b_ev_s   = b_rise_s   & ~conv_b_start;
  assign sc_ev_s  = HAS_SC & sc_rise_s & ~sc_start;
  assign add_ev_s = add_rise_s & ~add_start;

  assign sc_ok_s    = sc_ok_r | ~HAS_SC;
  assign b_now_s    = b_ok_r | b_ev_s;
  assign timeout_s  = (stage_cnt_r == TO_LAST);
  assign lat_next_s = (lat_cnt_r == CNT_MAX) ? lat_cnt_r : lat_cnt_r + CNT_ONE;

  // Sequencer state, stage timer, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      stage_cnt_r  <= CNT_ZERO;
      lat_cnt_r    <= CNT_ZERO;
      sc_ok_r      <= 1'b0;
      b_ok_r       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_stage    <= ERR_CONV_A;
      latency      <= CNT_ZERO;
      conv_a_start <= 1'b0;
      conv_b_start <= 1'b0;
      sc_start     <= 1'b0;
      add_start    <= 1'b0;
    end else begin
      conv_a_start <= 1'b0;
      conv_b_start <= 1'b0;
      sc_start     <= 1'b0;
      add_start    <= 1'b0;
      done         <= 1'b0;
      if (is_run(state_r)) begin
        stage_cnt_r <= stage_cnt_r + CNT_ONE;
        lat_cnt_r   <= lat_next_s;
        sc_ok_r     <= sc_ok_r | sc_ev_s;
      end
      case (state_r)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            state_r      <= ST_RUN_A;
            busy         <= 1'b1;
            error        <= 1'b0;
            err_stage    <= ERR_CONV_A;
            conv_a_start <= 1'b1;
            sc_start     <= HAS_SC;
            stage_cnt_r  <= CNT_ZERO;
            lat_cnt_r    <= CNT_ONE;
            sc_ok_r      <= 1'b0;
            b_ok_r       <= 1'b0;
          end
        end
        ST_RUN_A: begin
          if (a_ev_s) begin
            state_r      <= ST_RUN_B;
            conv_b_start <= 1'b1;
            stage_cnt_r  <= CNT_ZERO;
          end else if (timeout_s) begin
            state_r   <= ST_ERR;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_stage <= ERR_CONV_A;
          end
        end
        ST_RUN_B: begin
          if (b_now_s && (sc_ok_s || sc_ev_s)) begin
            state_r     <= ST_RUN_ADD;
            add_start   <= 1'b1;
            stage_cnt_r <= CNT_ZERO;
          end else if (timeout_s) begin
            // A late shortcut is charged to this stage once conv_b has finished
            state_r   <= ST_ERR;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_stage <= b_now_s ? ERR_SHORTCUT : ERR_CONV_B;
          end else begin
            b_ok_r <= b_now_s;
          end
        end
        ST_RUN_ADD: begin
          if (add_ev_s) begin
            state_r <= ST_FIN;
            done    <= 1'b1;
            latency <= lat_next_s;
          end else if (timeout_s) begin
            state_r   <= ST_ERR;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_stage <= ERR_ADD;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_res_block_seq.sv
// Scoreboard bench: u0 with projection shortcut (TIMEOUT 32), u1 identity shortcut (TIMEOUT 16).
module tb_res_block_seq;

  localparam int CW = 16;

  typedef struct {
    int         cyc;
    logic [4:0] ev;   // {done, add_start, conv_b_start, sc_start, conv_a_start}
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v, a_dv, b_dv, sc_dv, add_dv;
  logic [1:0] busy_v, done_v, error_v, a_sv, b_sv, sc_sv, add_sv;
  logic [1:0] err_stage0, err_stage1;
  logic [CW-1:0] lat0, lat1;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  res_block_seq #(.USE_SHORTCUT(1), .TIMEOUT(32), .CNT_WIDTH(CW)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .error(error_v[0]), .err_stage(err_stage0), .latency(lat0),
    .conv_a_start(a_sv[0]), .conv_b_start(b_sv[0]), .sc_start(sc_sv[0]), .add_start(add_sv[0]),
    .conv_a_done(a_dv[0]), .conv_b_done(b_dv[0]), .sc_done(sc_dv[0]), .add_done(add_dv[0]));

  res_block_seq #(.USE_SHORTCUT(0), .TIMEOUT(16), .CNT_WIDTH(CW)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .error(error_v[1]), .err_stage(err_stage1), .latency(lat1),
    .conv_a_start(a_sv[1]), .conv_b_start(b_sv[1]), .sc_start(sc_sv[1]), .add_start(add_sv[1]),
    .conv_a_done(a_dv[1]), .conv_b_done(b_dv[1]), .sc_done(sc_dv[1]), .add_done(add_dv[1]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int sel, input int c, input logic [4:0] ev, input int lat);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    e.lat = lat;
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic scan(input int sel, input logic [4:0] ev, input int lat);
    exp_t e;
    if (ev != 5'd0) begin
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
        check_eq($sformatf("u%0d_unexpected_pulse", sel), ev, 0);
      end else begin
        if (sel == 0) e = q0.pop_front();
        else e = q1.pop_front();
        check_eq($sformatf("u%0d_event_cycle", sel), cyc, e.cyc);
        check_eq($sformatf("u%0d_event_kind", sel), ev, e.ev);
        if (e.ev[4]) check_eq($sformatf("u%0d_latency", sel), lat, e.lat);
      end
    end
  endtask

  // Output monitor: every pulse must match the front of the expectation queue
  always @(negedge clk) begin
    scan(0, {done_v[0], add_sv[0], b_sv[0], sc_sv[0], a_sv[0]}, int'(lat0));
    scan(1, {done_v[1], add_sv[1], b_sv[1], sc_sv[1], a_sv[1]}, int'(lat1));
  end

  function automatic logic unit_done(input int k, input int r, input bit level,
                                     input bit pre_high, input bit ghost);
    if (level) return (pre_high && k < 3) || (r >= 0 && k >= r);
    return (k == r) || (ghost && k == 1);
  endfunction

  // Drive one run on instance sel; offsets are relative to the start cycle (k=0).
  task automatic run(input int sel, input int ra, input int rs, input int rb, input int rd,
                     input int len, input int n_ev, input bit level, input bit pre_high,
                     input bit ghost, input int extra_k, input int rst_k);
    int t;
    int add_at;
    bit hs;
    hs = (sel == 0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        t = cyc;
        add_at = (hs && rs > rb) ? rs : rb;
        if (n_ev > 0) push_exp(sel, t + 1, hs ? 5'b00011 : 5'b00001, 0);
        if (n_ev > 1) push_exp(sel, t + ra + 1, 5'b00100, 0);
        if (n_ev > 2) push_exp(sel, t + add_at + 1, 5'b01000, 0);
        if (n_ev > 3) push_exp(sel, t + rd + 1, 5'b10000, rd + 1);
      end
      start_v[sel] = (k == 0) || (k == extra_k);
      rst          = (k == rst_k);
      a_dv[sel]    = unit_done(k, ra, level, pre_high, ghost);
      sc_dv[sel]   = unit_done(k, rs, level, pre_high, ghost);
      b_dv[sel]    = unit_done(k, rb, level, pre_high, ghost);
      add_dv[sel]  = unit_done(k, rd, level, pre_high, ghost);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start_v = 2'b00;
      rst     = 1'b0;
    end
  endtask

  task automatic check_reset(input int sel, input string tag);
    if (sel == 0) begin
      check_eq({tag, "_busy"}, busy_v[0], 0);
      check_eq({tag, "_done"}, done_v[0], 0);
      check_eq({tag, "_error"}, error_v[0], 0);
      check_eq({tag, "_err_stage"}, err_stage0, 0);
      check_eq({tag, "_latency"}, lat0, 0);
      check_eq({tag, "_starts"}, {a_sv[0], b_sv[0], sc_sv[0], add_sv[0]}, 0);
    end else begin
      check_eq({tag, "_busy"}, busy_v[1], 0);
      check_eq({tag, "_done"}, done_v[1], 0);
      check_eq({tag, "_error"}, error_v[1], 0);
      check_eq({tag, "_err_stage"}, err_stage1, 0);
      check_eq({tag, "_latency"}, lat1, 0);
      check_eq({tag, "_starts"}, {a_sv[1], b_sv[1], sc_sv[1], add_sv[1]}, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_v = 2'b00;
    a_dv = 2'b00; b_dv = 2'b00; sc_dv = 2'b00; add_dv = 2'b00;
    repeat (3) @(negedge clk);
    check_reset(0, "u0_reset");
    check_reset(1, "u1_reset");
    idle(2);

    // nominal: starts T+1,T+1,T+11,T+21, done T+26, latency 26
    run(0, 10, 4, 20, 25, 30, 4, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("u0_nominal_busy_after", busy_v[0], 0);
    idle(2);
    // late shortcut: add_start waits for sc_done at T+30
    run(0, 10, 30, 20, 35, 40, 4, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(2);
    // done edges coinciding with the start pulses must be ignored
    run(0, 3, 9, 6, 12, 15, 4, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(2);
    // level-held done: first run leaves all dones high, second must wait for fresh edges
    run(0, 3, 2, 6, 9, 12, 4, 1'b1, 1'b0, 1'b0, -1, -1);
    idle(2);
    run(0, 8, 5, 12, 15, 18, 4, 1'b1, 1'b1, 1'b0, -1, -1);
    idle(2);
    // extra start while in RUN_B is ignored
    run(0, 10, 4, 20, 25, 30, 4, 1'b0, 1'b0, 1'b0, 15, -1);
    idle(2);
    // shortcut never completes: conv_b done, stage times out in RUN_B with err_stage 2
    run(0, 3, -1, 6, -1, 36, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("u0_sc_to_error_before", error_v[0], 0);
    check_eq("u0_sc_to_busy_before", busy_v[0], 1);
    idle(1);
    check_eq("u0_sc_to_error", error_v[0], 1);
    check_eq("u0_sc_to_err_stage", err_stage0, 2);
    check_eq("u0_sc_to_busy", busy_v[0], 0);
    idle(3);
    // rst while in RUN_ADD, then a minimum-length run
    run(0, 3, 2, 6, -1, 10, 3, 1'b0, 1'b0, 1'b0, -1, 9);
    idle(1);
    check_reset(0, "u0_midrun_rst");
    idle(2);
    run(0, 2, 2, 4, 6, 9, 4, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(2);

    // identity shortcut: no sc_start, add_start one cycle after conv_b_done
    run(1, 10, 4, 20, 25, 30, 4, 1'b0, 1'b0, 1'b0, -1, -1);
    idle(2);
    // conv_b never done: error 16 cycles after entering RUN_B
    run(1, 3, -1, -1, -1, 20, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("u1_to_error_before", error_v[1], 0);
    idle(1);
    check_eq("u1_to_error", error_v[1], 1);
    check_eq("u1_to_err_stage", err_stage1, 1);
    check_eq("u1_to_busy", busy_v[1], 0);
    idle(3);
    check_eq("u1_error_sticky", error_v[1], 1);
    // a fresh start clears the error and completes
    run(1, 3, 2, 6, 9, 12, 4, 1'b0, 1'b0, 1'b0, -1, -1);
    check_eq("u1_error_cleared", error_v[1], 0);
    check_eq("u1_recover_latency", lat1, 10);
    idle(3);

    check_eq("u0_pending_events", q0.size(), 0);
    check_eq("u1_pending_events", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/res_block_seq.md
# res_block_seq

Sequencer for one residual block: main path conv (3x3), ReLU, conv (3x3), shortcut conv1x1 projection, elementwise add. Issues single-cycle start pulses to each compute unit, tracks their done signals, overlaps the shortcut with the main path, and reports completion, per-stage timeouts and total run latency to the layer-level scheduler. It sits between the network controller and the existing start/done compute units; it never touches tensor data.

## Interface

Parameters:
- USE_SHORTCUT, 1: 1 = projection conv1x1 present and sequenced; 0 = identity shortcut, sc_start never pulses.
- TIMEOUT, 4096: max cycles any stage may wait for its done (must be ≥ 2).
- CNT_WIDTH, 16: width of timeout and latency counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one block run; honoured only in IDLE.
- busy  out  1  high from cycle after accepted start until DONE/ERR exit.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag; cleared by rst or next accepted start.
- err_stage  out  2  stage that timed out: 0 conv_a, 1 conv_b, 2 shortcut, 3 add.
- latency  out  CNT_WIDTH  cycles from accepted start to done, latched at done, saturating.
- conv_a_start, conv_b_start, sc_start, add_start  out  1 each  one-cycle start pulses.
- conv_a_done, conv_b_done, sc_done, add_done  in  1 each  unit done (pulse or level).

## Operation

- States: IDLE, RUN_A, RUN_B, RUN_ADD, FIN, ERR.
- Done detection: each *_done is rising-edge detected (registered previous value); level-held done from a previous run never counts. Rising edge in the same cycle as the matching start pulse is ignored.
- IDLE: start=1 -> RUN_A; conv_a_start=1 and (if USE_SHORTCUT) sc_start=1 next cycle; error cleared; latency counter reset to 1.
- RUN_A: on conv_a_done edge -> RUN_B, conv_b_start pulse next cycle. sc_done edge in any RUN state sets sticky sc_ok (forced 1 when USE_SHORTCUT=0).
- RUN_B: waits for conv_b_done edge; then if sc_ok (or sc_done edge same cycle) -> RUN_ADD with add_start pulse; else stays, waiting for sc_done.
- RUN_ADD: add_done edge -> FIN.
- FIN: done=1 for one cycle, latency latched, -> IDLE.
- Timeout: stage counter reloads to 0 on every state entry; reaching TIMEOUT-1 without the awaited edge -> ERR, err_stage set (in RUN_B after conv_b done, awaiting shortcut: err_stage=2; shortcut not done by end of RUN_B counts there, not in RUN_A). ERR: error=1, busy=0, stays until start -> behaves as IDLE accept.
- start while busy: ignored, no queuing.
- Latency counter saturates at all-ones.

## Timing

- Reset values: busy 0, done 0, error 0, err_stage 0, latency 0, all *_start 0, state IDLE, sc_ok 0.
- rst mid-run: next cycle all outputs at reset values; in-flight units are not aborted (caller resets them together).
- start at cycle T -> conv_a_start/sc_start high at T+1, busy high from T+1.
- Done edge at cycle D -> next stage start pulse at D+1.
- add_done edge at cycle E -> done at E+1; busy low at E+2.
- Minimum run (all units done 1 cycle after start): done at T+7.

## Structure

- Package res_block_pkg: state enum, err_stage encodings (ERR_CONV_A..ERR_ADD), default TIMEOUT.
- Sub-module edge_det (1-bit rising-edge detector with registered previous value), instantiated once per done input.
- Single always block for FSM plus counters; outputs registered.

## Test plan

- Nominal, USE_SHORTCUT=1: conv_a_done at T+10, sc_done at T+4, conv_b_done at T+20, add_done at T+25 -> starts at T+1,T+1,T+11,T+21; done at T+26; latency=26.
- Late shortcut: sc_done at T+30, conv_b_done T+20 -> add_start at T+31, never before.
- Level-held done: units hold done high between runs; second start -> no stage advances until each done falls and rises again.
- Timeout: TIMEOUT=16, conv_b_done never arrives -> error=1, err_stage=1, busy=0 after 16 cycles in RUN_B, done never pulses; next start clears error.
- Start while busy and rst mid-run: extra start in RUN_B ignored (one done only); rst in RUN_ADD -> all outputs reset next cycle, later start runs cleanly.
- USE_SHORTCUT=0: sc_start never pulses, add_start one cycle after conv_b_done.
